// File: rtl/mdu_ctl_if.sv
// mdu_ctl_if -- core-side request/response channel of the eJ32 multiply/divide
// sequencer.
//   req_valid/req_ready : request handshake (master drives valid)
//   req_op              : 00 MUL, 01 MULH, 10 DIV, 11 REM
//   req_a/req_b         : signed operands
//   rsp_valid/rsp_ready : response handshake (slave drives valid)
//   rsp_data/rsp_dbz    : result word and divide-by-zero flag
// Modports: master = core, slave = mdu_ctl.
`timescale 1ns/1ps
interface mdu_ctl_if #(
   parameter int unsigned DSZ = 32
);
   logic           req_valid;
   logic           req_ready;
   logic [1:0]     req_op;
   logic [DSZ-1:0] req_a;
   logic [DSZ-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [DSZ-1:0] rsp_data;
   logic           rsp_dbz;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_dbz
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_dbz
   );
endinterface

// File: rtl/mdu_ctl.sv
// mdu_ctl -- multiply/divide sequencer for the eJ32 ALU path.
// Accepts one request at a time, converts signed operands to magnitudes,
// drives the shared unsigned multiplier (combinational) or the iterative
// divider (start/busy), applies Java sign rules and returns one result.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   bus (mdu_ctl_if.slave)  : request/response handshake channel
//   mul_a, mul_b / mul_r    : magnitudes to multiplier / 2*DSZ unsigned product
//   div_start               : one-cycle start pulse to divider
//   div_x, div_y            : magnitudes to divider
//   div_busy, div_dbz       : divider iterating / zero-divisor flag
//   div_q, div_r            : unsigned quotient / remainder
// Optional feature: define MDU_DBZ_EN to short-circuit DIV/REM by zero
// (result 0, rsp_dbz=1, divider never started). Without it the divider runs
// on a zero divisor and rsp_dbz reflects div_dbz.
`timescale 1ns/1ps
module mdu_ctl #(
   parameter int unsigned DSZ = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   mdu_ctl_if.slave         bus,
   output logic [DSZ-1:0]   mul_a,
   output logic [DSZ-1:0]   mul_b,
   input  logic [2*DSZ-1:0] mul_r,
   output logic             div_start,
   output logic [DSZ-1:0]   div_x,
   output logic [DSZ-1:0]   div_y,
   input  logic             div_busy,
   input  logic             div_dbz,
   input  logic [DSZ-1:0]   div_q,
   input  logic [DSZ-1:0]   div_r
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DSTART,
      S_DWAIT,
      S_DONE
   } state_t;

   state_t           state;
   logic [1:0]       op;
   logic [DSZ-1:0]   mag_a;
   logic [DSZ-1:0]   mag_b;
   logic             sa;
   logic             sb;

   logic [DSZ-1:0]   abs_a;
   logic [DSZ-1:0]   abs_b;
   logic [2*DSZ-1:0] prod_s;
   logic [DSZ-1:0]   quo_s;
   logic [DSZ-1:0]   rem_s;

`ifdef MDU_DBZ_EN
   logic unused_div_dbz;
   assign unused_div_dbz = div_dbz;
`endif

   // Magnitudes wrap naturally: |min_int| stays 0x80..0 read as unsigned.
   always_comb begin
      abs_a  = bus.req_a[DSZ-1] ? ('0 - bus.req_a) : bus.req_a;
      abs_b  = bus.req_b[DSZ-1] ? ('0 - bus.req_b) : bus.req_b;
      prod_s = (sa ^ sb) ? ('0 - mul_r) : mul_r;
      quo_s  = (sa ^ sb) ? ('0 - div_q) : div_q;
      // Remainder sign follows the dividend only.
      rem_s  = sa ? ('0 - div_r) : div_r;
   end

   assign mul_a = mag_a;
   assign mul_b = mag_b;
   assign div_x = mag_a;
   assign div_y = mag_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_dbz   <= 1'b0;
         div_start     <= 1'b0;
         op            <= '0;
         mag_a         <= '0;
         mag_b         <= '0;
         sa            <= 1'b0;
         sb            <= 1'b0;
      end else begin
         div_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  op            <= bus.req_op;
                  mag_a         <= abs_a;
                  mag_b         <= abs_b;
                  sa            <= bus.req_a[DSZ-1];
                  sb            <= bus.req_b[DSZ-1];
                  bus.req_ready <= 1'b0;
                  if (!bus.req_op[1]) begin
                     state <= S_MUL;
`ifdef MDU_DBZ_EN
                  end else if (bus.req_b == '0) begin
                     state         <= S_DONE;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_data  <= '0;
                     bus.rsp_dbz   <= 1'b1;
`endif
                  end else begin
                     // div_start is registered, so it is high exactly while in DSTART.
                     state     <= S_DSTART;
                     div_start <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               bus.rsp_data  <= op[0] ? prod_s[2*DSZ-1:DSZ] : prod_s[DSZ-1:0];
               bus.rsp_dbz   <= 1'b0;
               bus.rsp_valid <= 1'b1;
               state         <= S_DONE;
            end
            S_DSTART: begin
               state <= S_DWAIT;
            end
            S_DWAIT: begin
               if (!div_busy) begin
                  bus.rsp_data  <= op[0] ? rem_s : quo_s;
`ifdef MDU_DBZ_EN
                  bus.rsp_dbz   <= 1'b0;
`else
                  bus.rsp_dbz   <= div_dbz;
`endif
                  bus.rsp_valid <= 1'b1;
                  state         <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
                  state         <= S_IDLE;
               end
            end
            default: begin
               state         <= S_IDLE;
               bus.req_ready <= 1'b1;
               bus.rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctl.sv
// tb_mdu_ctl -- self-checking bench for mdu_ctl with behavioural multiplier
// and iterative-divider models; expected results come from signed 64-bit
// arithmetic following the Java idiv/irem/imul rules.
`timescale 1ns/1ps
module tb_mdu_ctl;
   localparam int unsigned DSZ = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mdu_ctl_if #(.DSZ(DSZ)) bus ();

   logic [DSZ-1:0]   mul_a, mul_b, div_x, div_y, div_q, div_r;
   logic [2*DSZ-1:0] mul_r;
   logic             div_start, div_busy, div_dbz;

   mdu_ctl #(.DSZ(DSZ)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
      .div_start(div_start), .div_x(div_x), .div_y(div_y),
      .div_busy(div_busy), .div_dbz(div_dbz), .div_q(div_q), .div_r(div_r)
   );

   int checks = 0;
   int errors = 0;

   // Multiplier: unsigned combinational product.
   assign mul_r = {32'b0, mul_a} * {32'b0, mul_b};

   // Divider: not reset by rst_n; busy from power-up until the first start.
   int unsigned    div_lat_force = 0;
   int unsigned    dcnt = 0;
   logic [DSZ-1:0] pend_q, pend_r;
   logic           pend_dbz;
   initial begin
      div_busy = 1'b1; div_q = '1; div_r = '1; div_dbz = 1'b0;
      pend_q = '0; pend_r = '0; pend_dbz = 1'b0;
   end
   always @(posedge clk) begin
      if (div_start === 1'b1) begin
         dcnt     <= (div_lat_force != 0) ? div_lat_force : $urandom_range(6, 1);
         div_busy <= 1'b1;
         div_q    <= $urandom;
         div_r    <= $urandom;
         if (div_y == '0) begin
            pend_q <= '1; pend_r <= div_x; pend_dbz <= 1'b1;
         end else begin
            pend_q <= div_x / div_y; pend_r <= div_x % div_y; pend_dbz <= 1'b0;
         end
      end else if (div_busy && dcnt != 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1) begin
            div_busy <= 1'b0; div_q <= pend_q; div_r <= pend_r; div_dbz <= pend_dbz;
         end
      end
   end

   // Monitors: cycle count, div_start high cycles, acceptance edges.
   int unsigned cyc = 0;
   int unsigned start_cycles = 0;
   int unsigned acc_q[$];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (div_start === 1'b1) start_cycles <= start_cycles + 1;
      if (rst_n && bus.req_valid === 1'b1 && bus.req_ready === 1'b1) acc_q.push_back(cyc);
   end

   // Reference model: Java semantics via signed 64-bit arithmetic.
   function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic z);
      longint pa, pb;
      logic [63:0] p;
      pa = $signed(a);
      pb = $signed(b);
      z = 1'b0;
      d = '0;
      if (op == 2'b00 || op == 2'b01) begin
         p = pa * pb;
         d = (op == 2'b00) ? p[31:0] : p[63:32];
      end else if (b == '0) begin
         z = 1'b1;
`ifdef MDU_DBZ_EN
         d = '0;
`else
         if (op == 2'b10) d = a[31] ? 32'd1 : 32'hFFFF_FFFF;
         else d = a;
`endif
      end else begin
         p = (op == 2'b10) ? pa / pb : pa % pb;
         d = p[31:0];
      end
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(6, 0))
         0: v = 32'h0;
         1: v = 32'h8000_0000;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h7FFF_FFFF;
         4: begin v = $urandom_range(20, 0); v = v - 32'd10; end
         5: v = $urandom_range(1000, 1);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Drives one transaction and reports what was observed.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int unsigned hold, input bit poke,
                         output logic [31:0] d, output logic z, output int unsigned lat,
                         output int unsigned starts, output bit busy_ok, output bit stable_ok,
                         output bit idle_ok, output bit done);
      int unsigned s0, n, a1;
      busy_ok = 1; stable_ok = 1; idle_ok = 0; done = 0; lat = 0; d = '0; z = 1'b0; starts = 0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.rsp_ready = 1'b0;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin bus.req_valid = 1'b0; return; end
      s0 = start_cycles;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 200) begin
         if (bus.req_ready !== 1'b0) busy_ok = 0;
         @(posedge clk); #1;
         lat++;
      end
      if (bus.rsp_valid !== 1'b1) begin starts = start_cycles - s0; return; end
      if (bus.req_ready !== 1'b0) busy_ok = 0;
      d = bus.rsp_data; z = bus.rsp_dbz;
      a1 = acc_q.size();
      if (poke) bus.req_valid = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d || bus.rsp_dbz !== z ||
             bus.req_ready !== 1'b0) stable_ok = 0;
      end
      bus.req_valid = 1'b0;
      if (acc_q.size() != a1) stable_ok = 0;
      starts = start_cycles - s0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      idle_ok = (bus.rsp_valid === 1'b0 && bus.req_ready === 1'b1);
      done = 1;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
      checks++; if (bus.rsp_dbz !== 1'b0) begin errors++; $display("FAIL reset_rsp_dbz: got %b expected 0", bus.rsp_dbz); end
      checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start: got %b expected 0", div_start); end
      v = mul_a | mul_b | div_x | div_y;
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h expected 0", v); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul();
      logic [31:0] d; logic z; int unsigned lat, st; bit bo, so, io, dn;
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, d, z, lat, st, bo, so, io, dn);
      checks++; if (!dn || d !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data: got %h expected ffffffeb", d); end
      checks++; if (lat != 2) begin errors++; $display("FAIL mul_latency: got %0d expected 2", lat); end
      checks++; if (z !== 1'b0 || !bo || !io) begin errors++; $display("FAIL mul_flags: dbz %b busy_ok %0d idle_ok %0d expected 0 1 1", z, bo, io); end
      run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0, d, z, lat, st, bo, so, io, dn);
      checks++; if (!dn || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulh_data: got %h expected ffffffff", d); end
   endtask

   task automatic test_div_signs();
      logic [1:0]  ops[4] = '{2'b10, 2'b11, 2'b11, 2'b10};
      logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
      logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      logic [31:0] es[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD};
      logic [31:0] d; logic z; int unsigned lat, st; bit bo, so, io, dn;
      for (int unsigned i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], 1, 0, d, z, lat, st, bo, so, io, dn);
         checks++; if (!dn || d !== es[i]) begin errors++; $display("FAIL div_sign_%0d: got %h expected %h", i, d, es[i]); end
         checks++; if (st != 1) begin errors++; $display("FAIL div_start_width_%0d: got %0d cycles expected 1", i, st); end
         checks++; if (!bo || z !== 1'b0) begin errors++; $display("FAIL div_ready_low_%0d: busy_ok %0d dbz %b expected 1 0", i, bo, z); end
      end
   endtask

   task automatic test_overflow();
      logic [1:0]  ops[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
      logic [31:0] as[4]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] es[4]  = '{32'h8000_0000, 32'h0, 32'h4000_0000, 32'h8000_0000};
      logic [31:0] d; logic z; int unsigned lat, st; bit bo, so, io, dn;
      for (int unsigned i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], 0, 0, d, z, lat, st, bo, so, io, dn);
         checks++; if (!dn || d !== es[i]) begin errors++; $display("FAIL overflow_%0d: got %h expected %h", i, d, es[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d; logic z; int unsigned lat, st; bit bo, so, io, dn;
      run_op(2'b10, 32'd100, 32'd7, 5, 1, d, z, lat, st, bo, so, io, dn);
      checks++; if (!dn || d !== 32'd14) begin errors++; $display("FAIL bp_data: got %h expected 0000000e", d); end
      checks++; if (!so) begin errors++; $display("FAIL bp_stable: got unstable/accepted expected held"); end
      checks++; if (!io) begin errors++; $display("FAIL bp_idle_next: got not idle expected req_ready=1 rsp_valid=0"); end
      run_op(2'b00, 32'd6, 32'd7, 0, 0, d, z, lat, st, bo, so, io, dn);
      checks++; if (!dn || d !== 32'd42) begin errors++; $display("FAIL bp_next_mul: got %h expected 0000002a", d); end
   endtask

   task automatic test_div_by_zero();
      logic [31:0] d; logic z; int unsigned lat, st; bit bo, so, io, dn;
      run_op(2'b10, 32'd7, 32'd0, 0, 0, d, z, lat, st, bo, so, io, dn);
      checks++; if (!dn || z !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", z); end
`ifdef MDU_DBZ_EN
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL dbz_data: got %h expected 0", d); end
      checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
      checks++; if (st != 0) begin errors++; $display("FAIL dbz_no_start: got %0d start cycles expected 0", st); end
`else
      checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_data: got %h expected ffffffff", d); end
      checks++; if (st != 1) begin errors++; $display("FAIL dbz_start: got %0d start cycles expected 1", st); end
`endif
      run_op(2'b11, 32'd7, 32'd0, 0, 0, d, z, lat, st, bo, so, io, dn);
`ifdef MDU_DBZ_EN
      checks++; if (!dn || d !== 32'h0 || z !== 1'b1) begin errors++; $display("FAIL dbz_rem: got %h/%b expected 0/1", d, z); end
`else
      checks++; if (!dn || d !== 32'd7 || z !== 1'b1) begin errors++; $display("FAIL dbz_rem: got %h/%b expected 7/1", d, z); end
`endif
   endtask

   task automatic test_reset_mid_divide();
      logic [31:0] d; logic z; int unsigned lat, st, n; bit bo, so, io, dn;
      div_lat_force = 20;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_a = 32'd100; bus.req_b = 32'd3;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_immediate: got valid %b ready %b expected 0 1", bus.rsp_valid, bus.req_ready); end
      checks++; if (div_x !== 32'h0) begin errors++; $display("FAIL midrst_operands: got %h expected 0", div_x); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      div_lat_force = 0;
      run_op(2'b10, 32'd9, 32'd3, 0, 0, d, z, lat, st, bo, so, io, dn);
      checks++; if (!dn || d !== 32'd3) begin errors++; $display("FAIL midrst_div: got %h expected 00000003", d); end
      checks++; if (st != 1) begin errors++; $display("FAIL midrst_start: got %0d start cycles expected 1", st); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, e; logic ez; int unsigned a0, nresp;
      nresp = 0;
      a = pick(); b = pick();
      ref_op(2'b00, a, b, e, ez);
      @(negedge clk);
      a0 = acc_q.size();
      bus.req_op = 2'b00; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
      for (int unsigned i = 0; i < 13; i++) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) begin
            nresp++;
            checks++; if (bus.rsp_data !== e) begin errors++; $display("FAIL b2b_data: got %h expected %h", bus.rsp_data, e); end
         end
      end
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      bus.rsp_ready = 1'b0;
      checks++; if (acc_q.size() < a0 + 4 || nresp < 4) begin errors++; $display("FAIL b2b_count: got %0d accepts %0d responses expected >=4", acc_q.size() - a0, nresp); end
      for (int unsigned i = a0 + 1; i < acc_q.size(); i++) begin
         checks++; if (acc_q[i] - acc_q[i-1] != 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected 3", acc_q[i] - acc_q[i-1]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, d, e; logic [1:0] op; logic z, ez; int unsigned lat, st; bit bo, so, io, dn;
      for (int unsigned i = 0; i < 60; i++) begin
         op = 2'($urandom_range(3, 0));
         a = pick(); b = pick();
         ref_op(op, a, b, e, ez);
         run_op(op, a, b, $urandom_range(2, 0), 0, d, z, lat, st, bo, so, io, dn);
         checks++; if (!dn || d !== e || z !== ez) begin errors++; $display("FAIL rand_%0d op%0d %h,%h: got %h/%b expected %h/%b", i, op, a, b, d, z, e, ez); end
         checks++; if (!bo || !so || !io) begin errors++; $display("FAIL rand_hs_%0d: got busy %0d stable %0d idle %0d expected 1 1 1", i, bo, so, io); end
         if (!op[1]) begin
            checks++; if (lat != 2 || st != 0) begin errors++; $display("FAIL rand_mul_timing_%0d: got lat %0d starts %0d expected 2 0", i, lat, st); end
`ifdef MDU_DBZ_EN
         end else if (b == '0) begin
            checks++; if (lat != 1 || st != 0) begin errors++; $display("FAIL rand_dbz_timing_%0d: got lat %0d starts %0d expected 1 0", i, lat, st); end
`endif
         end else begin
            checks++; if (st != 1) begin errors++; $display("FAIL rand_div_start_%0d: got %0d expected 1", i, st); end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
      test_reset();
      test_mul();
      test_div_signs();
      test_overflow();
      test_backpressure();
      test_div_by_zero();
      test_reset_mid_divide();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
